// File: rtl/approx_eval_pkg.sv
// ---------------------------------------------------------------------------
// approx_eval_pkg
// Shared types and helpers for the approximate-multiplier evaluation stages.
//   sweepState_t : sweep controller states (IDLE, SWEEP, DRAIN, DONE)
//   DEFAULT_ET   : error threshold the default approximant was built for
//   abs_diff     : unsigned absolute difference, 32-bit so callers can
//                  compare the full result against thresholds without
//                  worrying about operand widths
// ---------------------------------------------------------------------------
package approx_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweepState_t;

    localparam int DEFAULT_ET = 8;

    // Absolute difference of two unsigned values; never wraps because the
    // larger operand is always the minuend.
    function automatic logic [31:0] abs_diff(input logic [31:0] a,
                                             input logic [31:0] b);
        if (a >= b) begin
            return a - b;
        end
        return b - a;
    endfunction

endpackage

// File: rtl/approx_err_accum.sv
// ---------------------------------------------------------------------------
// approx_err_accum
// Stage-2 error accumulator: takes one (exact, approx) pair per valid cycle
// and folds its absolute error into running max / sum / violation count.
// Ports:
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_clear         : synchronous clear of all accumulators (new sweep)
//   i_valid         : i_exact / i_approx hold a sample this cycle
//   i_exact         : exact product
//   i_approx        : approximate product (already zero-extended)
//   o_maxErr        : largest absolute error seen since clear
//   o_sumErr        : sum of absolute errors since clear
//   o_violCnt       : number of samples whose error exceeded ET
// ---------------------------------------------------------------------------
module approx_err_accum
    import approx_eval_pkg::*;
#(
    parameter int W     = 4,
    parameter int SUM_W = 2 * W,
    parameter int CNT_W = W + 1,
    parameter int ET    = DEFAULT_ET
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [W-1:0]     i_exact,
    input  logic [W-1:0]     i_approx,
    output logic [W-1:0]     o_maxErr,
    output logic [SUM_W-1:0] o_sumErr,
    output logic [CNT_W-1:0] o_violCnt
);

    logic [31:0]      w_errFull;
    logic [W-1:0]     r_maxErr;
    logic [SUM_W-1:0] r_sumErr;
    logic [CNT_W-1:0] r_violCnt;

    // The error is kept at full 32-bit width so the max and threshold
    // comparisons see every bit; it never actually exceeds W bits because
    // both operands are W bits wide.
    assign w_errFull = abs_diff(32'(i_exact), 32'(i_approx));

    // Accumulators: reset and clear both return to zero, clear wins over a
    // coincident sample so a restart never inherits data from the old sweep.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_maxErr  <= '0;
            r_sumErr  <= '0;
            r_violCnt <= '0;
        end else if (i_valid) begin
            if (w_errFull > 32'(r_maxErr)) begin
                r_maxErr <= w_errFull[W-1:0];
            end
            r_sumErr <= r_sumErr + w_errFull[SUM_W-1:0];
            if (w_errFull > 32'(ET)) begin
                r_violCnt <= r_violCnt + CNT_W'(1);
            end
        end
    end

    assign o_maxErr  = r_maxErr;
    assign o_sumErr  = r_sumErr;
    assign o_violCnt = r_violCnt;

endmodule

// File: rtl/approx_mul_err_sweep.sv
// ---------------------------------------------------------------------------
// approx_mul_err_sweep
// Exhaustively drives every input vector into a combinational approximate
// multiplier, compares each product with the exact one and reports the
// error statistics once the sweep has finished.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_start       : begin a sweep (only honoured in IDLE or DONE)
//   o_busy        : sweep in progress (SWEEP or DRAIN)
//   o_done        : results valid, held until the next accepted start
//   o_dutIn       : vector to the approximant; A = low half, B = high half
//   i_dutOut      : approximant product, unsigned
//   o_maxErr      : maximum absolute error over the sweep
//   o_sumErr      : sum of absolute errors
//   o_violCnt     : samples with absolute error above ET
//   o_pass        : done and max error within ET
// ---------------------------------------------------------------------------
module approx_mul_err_sweep
    import approx_eval_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int ET    = DEFAULT_ET
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [N_IN-1:0]   o_dutIn,
    input  logic [N_OUT-1:0]  i_dutOut,
    output logic [N_IN-1:0]   o_maxErr,
    output logic [2*N_IN-1:0] o_sumErr,
    output logic [N_IN:0]     o_violCnt,
    output logic              o_pass
);

    localparam int H = N_IN / 2;
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    sweepState_t       r_state;
    logic [N_IN-1:0]   r_vec;
    logic [N_IN-1:0]   r_exact;
    logic [N_IN-1:0]   r_approx;
    logic              r_valid;

    logic              w_accept;
    logic [H-1:0]      w_opA;
    logic [H-1:0]      w_opB;
    logic [N_IN-1:0]   w_prod;
    logic [N_IN-1:0]   w_approx;

    // A start only counts when the controller is idle or parked in DONE;
    // the same edge wipes the accumulators and the vector counter.
    assign w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));

    // Operands are the two halves of the vector currently on o_dutIn; the
    // product of two H-bit values always fits in N_IN bits.
    assign w_opA    = r_vec[H-1:0];
    assign w_opB    = r_vec[N_IN-1:H];
    assign w_prod   = {{(N_IN-H){1'b0}}, w_opA} * {{H{1'b0}}, w_opB};
    assign w_approx = N_IN'(i_dutOut);

    // Controller, vector counter and stage-1 capture. DRAIN waits for the
    // stage-1 valid to empty so the last sample is absorbed by the
    // accumulator before DONE is announced.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_vec    <= '0;
            r_exact  <= '0;
            r_approx <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid  <= (r_state == SWEEP);
            r_exact  <= w_prod;
            r_approx <= w_approx;
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_state <= SWEEP;
                        r_vec   <= '0;
                    end
                end
                SWEEP: begin
                    if (r_vec == VEC_LAST) begin
                        r_state <= DRAIN;
                        r_vec   <= '0;
                    end else begin
                        r_vec <= r_vec + N_IN'(1);
                    end
                end
                DRAIN: begin
                    if (!r_valid) begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    approx_err_accum #(
        .W     (N_IN),
        .SUM_W (2 * N_IN),
        .CNT_W (N_IN + 1),
        .ET    (ET)
    ) u_accum (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_accept),
        .i_valid   (r_valid),
        .i_exact   (r_exact),
        .i_approx  (r_approx),
        .o_maxErr  (o_maxErr),
        .o_sumErr  (o_sumErr),
        .o_violCnt (o_violCnt)
    );

    assign o_dutIn = (r_state == SWEEP) ? r_vec : '0;
    assign o_busy  = (r_state == SWEEP) || (r_state == DRAIN);
    assign o_done  = (r_state == DONE);
    assign o_pass  = o_done && (32'(o_maxErr) <= 32'(ET));

endmodule

// File: tb/tb_approx_mul_err_sweep.sv
// ---------------------------------------------------------------------------
// tb_approx_mul_err_sweep
// Drives directed sweeps against three behavioural approximants (exact,
// constant zero, stuck at all-ones). Expected statistics are hand-computed
// and queued when a sweep is launched; a monitor pops them when done rises.
// ---------------------------------------------------------------------------
module tb_approx_mul_err_sweep;

    typedef struct {
        int maxErr;
        int sumErr;
        int viol;
        int pass;
        int latency;
    } expect_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] dutIn;
    logic [3:0] dutOut;
    logic [3:0] maxErr;
    logic [7:0] sumErr;
    logic [4:0] violCnt;
    logic       pass;

    int      mode;
    int      errors;
    int      checks;
    int      cyc;
    logic    prevDone;
    expect_t expQ[$];

    approx_mul_err_sweep dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .o_busy    (busy),
        .o_done    (done),
        .o_dutIn   (dutIn),
        .i_dutOut  (dutOut),
        .o_maxErr  (maxErr),
        .o_sumErr  (sumErr),
        .o_violCnt (violCnt),
        .o_pass    (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural approximant: 0 = exact multiplier, 1 = always zero,
    // 2 = stuck at 4'hF.
    always_comb begin
        dutOut = 4'h0;
        case (mode)
            0:       dutOut = 4'({2'b00, dutIn[1:0]} * {2'b00, dutIn[3:2]});
            1:       dutOut = 4'h0;
            default: dutOut = 4'hF;
        endcase
    end

    task automatic checkOutput(input string name, input int actual,
                               input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Edges since the accepting start edge (accept edge = 0).
    always @(posedge clk) begin
        if (rst) begin
            cyc = -1;
        end else if (start && !busy) begin
            cyc = 0;
        end else if (cyc >= 0) begin
            cyc++;
        end
    end

    // Monitor: on each rising done, pop the expectation for that sweep.
    always @(negedge clk) begin
        if (rst) begin
            prevDone = 1'b0;
        end else begin
            if (done && !prevDone) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected done", 1, 0);
                end else begin
                    expect_t e;
                    e = expQ.pop_front();
                    checkOutput("done latency", cyc, e.latency);
                    checkOutput("max_err", int'(maxErr), e.maxErr);
                    checkOutput("sum_err", int'(sumErr), e.sumErr);
                    checkOutput("viol_cnt", int'(violCnt), e.viol);
                    checkOutput("pass", int'(pass), e.pass);
                end
            end
            prevDone = done;
        end
    end

    task automatic pushExpect(input int eMax, input int eSum, input int eViol,
                              input int ePass);
        expect_t e;
        e.maxErr  = eMax;
        e.sumErr  = eSum;
        e.viol    = eViol;
        e.pass    = ePass;
        e.latency = 18;
        expQ.push_back(e);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checkOutput("done timeout", 0, 1);
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int m, input int eMax, input int eSum,
                                 input int eViol, input int ePass);
        mode = m;
        pushExpect(eMax, eSum, eViol, ePass);
        pulseStart();
        waitDone();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] simulation did not terminate");
    end

    initial begin
        errors = 0;
        checks = 0;
        mode   = 0;
        start  = 1'b0;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset pass", int'(pass), 0);
        checkOutput("reset dut_in", int'(dutIn), 0);
        checkOutput("reset max_err", int'(maxErr), 0);
        checkOutput("reset sum_err", int'(sumErr), 0);
        checkOutput("reset viol_cnt", int'(violCnt), 0);
        rst = 1'b0;

        // Exact approximant, with a trace of every vector presented.
        mode = 0;
        pushExpect(0, 0, 0, 1);
        pulseStart();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            checkOutput($sformatf("dut_in trace %0d", i), int'(dutIn),
                        (i < 16) ? i : 0);
        end
        waitDone();

        // Zero approximant: errors are the exact products themselves.
        applyStimulus(1, 9, 36, 1, 0);
        // Stuck-high approximant: error is 15 - A*B.
        applyStimulus(2, 15, 204, 15, 0);

        // Reset partway through a sweep discards everything.
        mode = 2;
        pulseStart();
        repeat (7) @(negedge clk);
        checkOutput("mid-sweep busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset busy", int'(busy), 0);
        checkOutput("post-reset done", int'(done), 0);
        checkOutput("post-reset dut_in", int'(dutIn), 0);
        checkOutput("post-reset max_err", int'(maxErr), 0);
        checkOutput("post-reset sum_err", int'(sumErr), 0);
        checkOutput("post-reset viol_cnt", int'(violCnt), 0);
        checkOutput("post-reset pass", int'(pass), 0);

        // Start held high: no restart before DONE, then an immediate restart.
        mode = 1;
        pushExpect(9, 36, 1, 0);
        pushExpect(9, 36, 1, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        waitDone();
        checkOutput("restart busy", int'(busy), 1);
        checkOutput("restart done", int'(done), 0);
        checkOutput("restart max_err", int'(maxErr), 0);
        checkOutput("restart sum_err", int'(sumErr), 0);
        checkOutput("restart viol_cnt", int'(violCnt), 0);
        start = 1'b0;
        waitDone();

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
